// File: rtl/imm_rotate_encoder_if.sv
// Request/result bundle for imm_rotate_encoder: start/value in, busy/done/result out.
interface imm_rotate_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        ok;
  logic        inv;
  logic [11:0] shift_operand;

  modport master (
    output start, value,
    input  busy, done, ok, inv, shift_operand
  );

  modport slave (
    input  start, value,
    output busy, done, ok, inv, shift_operand
  );
endinterface

// File: rtl/imm_rotate_encoder.sv
// Multi-cycle search for an ARM rotated-immediate encoding {rot, imm8} of a 32-bit constant.
// Optional IMM_ENC_INV_EN adds a second pass over ~value (MVN form) reported through inv.
module imm_rotate_encoder #(
  parameter int LOW_ROT_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  imm_rotate_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
`ifdef IMM_ENC_INV_EN
    NSEARCH = 2'd3,
`endif
    DONE    = 2'd2
  } state_t;

  localparam logic [3:0] FIRST_R = (LOW_ROT_FIRST != 0) ? 4'd0  : 4'd15;
  localparam logic [3:0] LAST_R  = (LOW_ROT_FIRST != 0) ? 4'd15 : 4'd0;

  state_t      state_q, state_d;
  logic [31:0] v_q, v_d;
  logic [3:0]  r_q, r_d;
  logic        ok_q, ok_d;
  logic        inv_q, inv_d;
  logic [11:0] so_q, so_d;
  logic        busy_q, done_q;

  logic [31:0] cand;
  logic [63:0] rot_pair;
  logic [31:0] w;
  logic        hit;
  logic [3:0]  r_step;

  // The candidate is ~v_q only during the inverted pass; the rotate is done on a
  // doubled word so the upper half is the wrap-around left rotate by 2*r.
`ifdef IMM_ENC_INV_EN
  assign cand = (state_q == NSEARCH) ? ~v_q : v_q;
`else
  assign cand = v_q;
`endif
  assign rot_pair = {cand, cand} << {r_q, 1'b0};
  assign w        = rot_pair[63:32];
  assign hit      = (w[31:8] == 24'd0);
  assign r_step   = (LOW_ROT_FIRST != 0) ? (r_q + 4'd1) : (r_q - 4'd1);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    v_d     = v_q;
    r_d     = r_q;
    ok_d    = ok_q;
    inv_d   = inv_q;
    so_d    = so_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          v_d     = bus.value;
          r_d     = FIRST_R;
          ok_d    = 1'b0;
          inv_d   = 1'b0;
          so_d    = 12'd0;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        if (hit) begin
          ok_d    = 1'b1;
          so_d    = {r_q, w[7:0]};
          state_d = DONE;
        end else if (r_q == LAST_R) begin
`ifdef IMM_ENC_INV_EN
          r_d     = FIRST_R;
          state_d = NSEARCH;
`else
          ok_d    = 1'b0;
          state_d = DONE;
`endif
        end else begin
          r_d = r_step;
        end
      end

`ifdef IMM_ENC_INV_EN
      NSEARCH: begin
        if (hit) begin
          ok_d    = 1'b1;
          inv_d   = 1'b1;
          so_d    = {r_q, w[7:0]};
          state_d = DONE;
        end else if (r_q == LAST_R) begin
          ok_d    = 1'b0;
          inv_d   = 1'b0;
          so_d    = 12'd0;
          state_d = DONE;
        end else begin
          r_d = r_step;
        end
      end
`endif

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/done are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= 32'd0;
      r_q     <= 4'd0;
      ok_q    <= 1'b0;
      inv_q   <= 1'b0;
      so_q    <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      v_q     <= v_d;
      r_q     <= r_d;
      ok_q    <= ok_d;
      inv_q   <= inv_d;
      so_q    <= so_d;
`ifdef IMM_ENC_INV_EN
      busy_q  <= (state_d == SEARCH) || (state_d == NSEARCH);
`else
      busy_q  <= (state_d == SEARCH);
`endif
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.ok            = ok_q;
  assign bus.inv           = inv_q;
  assign bus.shift_operand = so_q;

endmodule
